// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: the data byte MSB index, the
// one-hot arbiter state encodings and the default SEND timeout length.
package uart_pkg;

    localparam int D_BIT           = 7;
    localparam int ARB_TIMEOUT_CYC = 100000;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t ARB_IDLE = 3'b001;
    localparam arb_state_t ARB_SEND = 3'b010;
    localparam arb_state_t ARB_GAP  = 3'b100;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector. Returns the first set bit of
// req searching upward from ptr+1 (wrapping), plus a flag that any bit is set.
// Kept free of UART specifics so other shared resources can reuse it.
module rr_picker #(
    parameter int N_REQ = 2,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    winner,
    output logic             any
);

    int best_dist;

    // Pick the requester with the smallest rotational distance past ptr
    always_comb begin
        winner    = ptr;
        best_dist = N_REQ;
        any       = |req;
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && (((i + N_REQ - 1 - int'(ptr)) % N_REQ) < best_dist)) begin
                best_dist = (i + N_REQ - 1 - int'(ptr)) % N_REQ;
                winner    = PW'(i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among N_REQ byte sources with
// round-robin selection. IDLE latches the winning byte, SEND holds tx_start
// until tx_done, GAP drops tx_start for one cycle before the next grant.
// Optional SEND watchdog: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int D_BIT       = uart_pkg::D_BIT,
    parameter int TIMEOUT_CYC = uart_pkg::ARB_TIMEOUT_CYC
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*(D_BIT+1)-1:0] req_dato,
    output logic [N_REQ-1:0]           grant,
    output logic [N_REQ-1:0]           done,
    output logic [D_BIT:0]             tx_dato_in,
    output logic                       tx_start,
    input  logic                       tx_done,
    output logic                       busy,
    output logic                       tx_timeout
);

    localparam int PW = $clog2(N_REQ);
    localparam int BW = D_BIT + 1;

    arb_state_t        state_reg, state_next;
    logic [PW-1:0]     ptr_reg, ptr_next;
    logic [D_BIT:0]    dato_reg, dato_next;
    logic [PW-1:0]     winner;
    logic              any_req;
    logic [D_BIT:0]    req_byte [N_REQ];
    logic [N_REQ-1:0]  win_onehot, ptr_onehot;
    logic [N_REQ-1:0]  grant_reg, grant_next;
    logic [N_REQ-1:0]  done_reg, done_next;
    logic              timeout_hit;

    rr_picker #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_picker (
        .req    (req),
        .ptr    (ptr_reg),
        .winner (winner),
        .any    (any_req)
    );

    // Unpack requester bytes and decode winner / current owner to one-hot
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign req_byte[gi]   = req_dato[gi*BW +: BW];
        assign win_onehot[gi] = (winner == PW'(gi));
        assign ptr_onehot[gi] = (ptr_reg == PW'(gi));
    end

    // State, round-robin pointer and latched byte; ptr resets so requester 0 wins first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ARB_IDLE;
            ptr_reg   <= PW'(N_REQ - 1);
            dato_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            dato_reg  <= dato_next;
        end
    end

    // Next-state: grant in IDLE, finish SEND on tx_done or watchdog, GAP lasts one cycle
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        dato_next  = dato_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (any_req) begin
                    state_next = ARB_SEND;
                    ptr_next   = winner;
                    dato_next  = req_byte[winner];
                end
            end
            ARB_SEND: begin
                if (tx_done || timeout_hit) begin
                    state_next = ARB_GAP;
                end
            end
            ARB_GAP:  state_next = ARB_IDLE;
            default:  state_next = ARB_IDLE;
        endcase
    end

    // Outputs: start/busy decode from state; grant/done pulses computed for registering
    always_comb begin
        tx_start   = (state_reg == ARB_SEND);
        busy       = (state_reg != ARB_IDLE);
        grant_next = '0;
        done_next  = '0;
        if (state_reg == ARB_IDLE && any_req) begin
            grant_next = win_onehot;
        end
        if (state_reg == ARB_SEND && tx_done) begin
            done_next = ptr_onehot;
        end
    end

    // Register the one-cycle grant and done pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_reg <= '0;
            done_reg  <= '0;
        end else begin
            grant_reg <= grant_next;
            done_reg  <= done_next;
        end
    end

    assign grant      = grant_reg;
    assign done       = done_reg;
    assign tx_dato_in = dato_reg;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] cnt_reg;
    logic             timeout_reg;

    // SEND dwell counter: zero outside SEND so it restarts on every entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (state_reg != ARB_SEND) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign timeout_hit = (state_reg == ARB_SEND) && (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

    // Abort pulse; a tx_done arriving on the terminal count takes precedence
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= timeout_hit && !tx_done;
        end
    end

    assign tx_timeout = timeout_reg;
`else
    assign timeout_hit = 1'b0;
    assign tx_timeout  = 1'b0;
`endif

endmodule
